// File: rtl/led_scheduler_pkg.sv
// Shared definitions for the LED pattern scheduler: state encoding, duration width, defaults.
// Optional blink feature is enabled by defining LED_SCHEDULER_BLINK_EN.
package led_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam int DUR_W            = 8;
    localparam int DEF_NUM_LEDS     = 4;
    localparam int DEF_TICK_DIVIDER = 125000;
    localparam int DEF_FIFO_DEPTH   = 4;

    // A zero duration still shows the pattern for one tick.
    function automatic logic [DUR_W-1:0] clamp_duration(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/led_scheduler_fifo.sv
// Show-ahead synchronous FIFO holding pending LED pattern requests.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module led_scheduler_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             ext_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Full is judged before any same-cycle pop: no write-through.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge ext_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// Plays buffered LED patterns, each for a number of display ticks, back to back.
// Define LED_SCHEDULER_BLINK_EN to add a per-entry blink flag (input_blink).
module led_scheduler
    import led_scheduler_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int TICK_DIVIDER = DEF_TICK_DIVIDER,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                ext_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                input_valid,
    output logic                input_ready,
`ifdef LED_SCHEDULER_BLINK_EN
    input  logic                input_blink,
`endif
    input  logic [NUM_LEDS-1:0] input_pattern,
    input  logic [DUR_W-1:0]    input_duration,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy,
    output logic                done
);
    localparam int PS_W = $clog2(TICK_DIVIDER);
`ifdef LED_SCHEDULER_BLINK_EN
    localparam int ENTRY_W = NUM_LEDS + DUR_W + 1;
`else
    localparam int ENTRY_W = NUM_LEDS + DUR_W;
`endif

    state_t              state_reg, state_next;
    logic [PS_W-1:0]     prescaler_reg, prescaler_next;
    logic [DUR_W-1:0]    remaining_reg, remaining_next;
    logic [NUM_LEDS-1:0] led_reg, led_next;
    logic                done_reg, done_next;
`ifdef LED_SCHEDULER_BLINK_EN
    logic [NUM_LEDS-1:0] pattern_reg, pattern_next;
    logic                blink_reg, blink_next;
    logic                phase_reg, phase_next;
`endif

    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                load;
    logic                tick;

`ifdef LED_SCHEDULER_BLINK_EN
    assign push_data = {input_blink, input_duration, input_pattern};
`else
    assign push_data = {input_duration, input_pattern};
`endif

    led_scheduler_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ext_clk   (ext_clk),
        .reset     (reset),
        .push      (input_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tick = (state_reg == ST_SHOW) && (prescaler_reg == PS_W'(TICK_DIVIDER - 1));

    always_comb begin
        state_next     = state_reg;
        prescaler_next = prescaler_reg;
        remaining_next = remaining_reg;
        led_next       = led_reg;
        done_next      = 1'b0;
        load           = 1'b0;
`ifdef LED_SCHEDULER_BLINK_EN
        pattern_next   = pattern_reg;
        blink_next     = blink_reg;
        phase_next     = phase_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                led_next = '0;
                if (enable && !fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_SHOW: begin
                prescaler_next = tick ? '0 : prescaler_reg + PS_W'(1);
                if (tick) begin
                    if (remaining_reg == DUR_W'(1)) begin
                        if (enable && !fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                            led_next   = '0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        remaining_next = remaining_reg - DUR_W'(1);
`ifdef LED_SCHEDULER_BLINK_EN
                        // phase_reg==0 means the pattern was lit during the tick just ending.
                        phase_next = ~phase_reg;
                        led_next   = (blink_reg && !phase_reg) ? '0 : pattern_reg;
`endif
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Loading the head is shared by the IDLE start and the gapless chain on expiry.
        if (load) begin
            state_next     = ST_SHOW;
            prescaler_next = '0;
            remaining_next = clamp_duration(head[NUM_LEDS +: DUR_W]);
            led_next       = head[NUM_LEDS-1:0];
`ifdef LED_SCHEDULER_BLINK_EN
            pattern_next   = head[NUM_LEDS-1:0];
            blink_next     = head[ENTRY_W-1];
            phase_next     = 1'b0;
`endif
        end
    end

    assign pop = load;

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            prescaler_reg <= '0;
            remaining_reg <= '0;
            led_reg       <= '0;
            done_reg      <= 1'b0;
`ifdef LED_SCHEDULER_BLINK_EN
            pattern_reg   <= '0;
            blink_reg     <= 1'b0;
            phase_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            prescaler_reg <= prescaler_next;
            remaining_reg <= remaining_next;
            led_reg       <= led_next;
            done_reg      <= done_next;
`ifdef LED_SCHEDULER_BLINK_EN
            pattern_reg   <= pattern_next;
            blink_reg     <= blink_next;
            phase_reg     <= phase_next;
`endif
        end
    end

    assign led_out     = led_reg;
    assign busy        = (state_reg == ST_SHOW);
    assign done        = done_reg;
    assign input_ready = !fifo_full;

endmodule

// File: tb/tb_led_scheduler.sv
// Self-checking bench for led_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count reference model of the playback rules.
module tb_led_scheduler;
    localparam int NL = 4;
    localparam int TD = 4;
    localparam int FD = 4;

    logic          ext_clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          input_valid;
    logic          input_ready;
    logic [NL-1:0] input_pattern;
    logic [7:0]    input_duration;
    logic [NL-1:0] led_out;
    logic          busy;
    logic          done;
`ifdef LED_SCHEDULER_BLINK_EN
    logic          input_blink;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: pending entries and the entry on display.
    logic [NL-1:0] q_pat [$];
    int            q_dur [$];
    bit            q_blk [$];
    bit            m_show;
    int            m_left;
    int            m_elapsed;
    logic [NL-1:0] m_pat;
    bit            m_blk;
    logic [NL-1:0] exp_led;
    bit            exp_busy;
    bit            exp_done;
    bit            exp_ready;

    led_scheduler #(
        .NUM_LEDS     (NL),
        .TICK_DIVIDER (TD),
        .FIFO_DEPTH   (FD)
    ) dut (
        .ext_clk        (ext_clk),
        .reset          (reset),
        .enable         (enable),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
`ifdef LED_SCHEDULER_BLINK_EN
        .input_blink    (input_blink),
`endif
        .input_pattern  (input_pattern),
        .input_duration (input_duration),
        .led_out        (led_out),
        .busy           (busy),
        .done           (done)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check_value("led_out", 32'(led_out), 32'(exp_led));
        check_value("busy", 32'(busy), 32'(exp_busy));
        check_value("done", 32'(done), 32'(exp_done));
        check_value("input_ready", 32'(input_ready), 32'(exp_ready));
    endtask

    task automatic model_reset();
        q_pat.delete();
        q_dur.delete();
        q_blk.delete();
        m_show    = 1'b0;
        m_left    = 0;
        m_elapsed = 0;
        m_pat     = '0;
        m_blk     = 1'b0;
        exp_led   = '0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic model_load();
        int d;
        m_pat     = q_pat.pop_front();
        d         = q_dur.pop_front();
        m_blk     = q_blk.pop_front();
        m_left    = ((d == 0) ? 1 : d) * TD;
        m_elapsed = 0;
        m_show    = 1'b1;
    endtask

    // Advance the model across one rising edge given the inputs sampled there.
    task automatic model_edge(input bit en, input bit v, input logic [NL-1:0] pat,
                              input int dur, input bit bl, output bit acc);
        bit nonempty;
        acc      = v && (q_pat.size() < FD);
        nonempty = (q_pat.size() != 0);
        exp_done = 1'b0;
        if (m_show) begin
            m_left--;
            m_elapsed++;
            if (m_left == 0) begin
                if (en && nonempty) model_load();
                else begin
                    m_show   = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end else if (en && nonempty) begin
            model_load();
        end
        if (acc) begin
            q_pat.push_back(pat);
            q_dur.push_back(dur);
`ifdef LED_SCHEDULER_BLINK_EN
            q_blk.push_back(bl);
`else
            q_blk.push_back(bl & 1'b0);
`endif
        end
        if (!m_show) exp_led = '0;
        else if (m_blk && ((m_elapsed / TD) % 2 == 1)) exp_led = '0;
        else exp_led = m_pat;
        exp_busy  = m_show;
        exp_ready = (q_pat.size() < FD);
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input bit en, input bit v, input logic [NL-1:0] pat,
                        input int dur, input bit bl);
        bit acc;
        enable         = en;
        input_valid    = v;
        input_pattern  = pat;
        input_duration = dur[7:0];
`ifdef LED_SCHEDULER_BLINK_EN
        input_blink    = bl;
`endif
        model_edge(en, v, pat, dur, bl, acc);
        @(posedge ext_clk);
        @(negedge ext_clk);
        if (acc) $display("push pattern=%b duration=%0d blink=%0d enable=%0d", pat, dur, bl, en);
        check_all();
    endtask

    task automatic idle_cycles(input bit en, input int n);
        for (int i = 0; i < n; i++) step(en, 1'b0, '0, 0, 1'b0);
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear immediately.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        input_valid = 1'b0;
        enable      = 1'b1;
        #1;
        model_reset();
        $display("reset asserted mid-cycle");
        check_value("rst_led_out", 32'(led_out), 32'(exp_led));
        check_value("rst_busy", 32'(busy), 32'(exp_busy));
        check_value("rst_input_ready", 32'(input_ready), 32'(exp_ready));
        check_value("rst_done", 32'(done), 32'(exp_done));
        @(negedge ext_clk);
        @(negedge ext_clk);
        reset = 1'b0;
    endtask

    initial begin
        bit en_r;
        int dur_r;
        reset          = 1'b1;
        enable         = 1'b0;
        input_valid    = 1'b0;
        input_pattern  = '0;
        input_duration = '0;
`ifdef LED_SCHEDULER_BLINK_EN
        input_blink    = 1'b0;
`endif
        model_reset();
        #1;
        check_value("reset_led_out", 32'(led_out), 32'(exp_led));
        check_value("reset_busy", 32'(busy), 32'(exp_busy));
        check_value("reset_done", 32'(done), 32'(exp_done));
        check_value("reset_input_ready", 32'(input_ready), 32'(exp_ready));
        @(negedge ext_clk);
        reset = 1'b0;

        // Single entry: shown one edge after accept for 3 ticks, then done.
        step(1'b1, 1'b1, 4'b1010, 3, 1'b0);
        idle_cycles(1'b1, 16);

        // Enable low: only FIFO_DEPTH entries accepted, nothing displayed.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(i + 1), 1, 1'b0);
        idle_cycles(1'b0, 4);
        idle_cycles(1'b1, 24);

        // Two chained entries with no gap and a single done.
        step(1'b1, 1'b1, 4'b0001, 2, 1'b0);
        step(1'b1, 1'b1, 4'b0010, 1, 1'b0);
        idle_cycles(1'b1, 16);

        // Enable dropped mid-entry: current entry completes, the next stays queued.
        step(1'b1, 1'b1, 4'b0100, 2, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 2, 1'b0);
        step(1'b1, 1'b0, '0, 0, 1'b0);
        idle_cycles(1'b0, 12);
        idle_cycles(1'b1, 12);

        // Duration 0 behaves as 1 tick; duration 255 lasts 255 ticks.
        step(1'b1, 1'b1, 4'b0110, 0, 1'b0);
        idle_cycles(1'b1, 8);
        step(1'b1, 1'b1, 4'b1001, 255, 1'b0);
        idle_cycles(1'b1, 255 * TD + 4);

        // Reset during SHOW with three entries buffered.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(4'hC + i), 3, 1'b0);
        idle_cycles(1'b1, 3);
        async_reset_pulse();
        idle_cycles(1'b1, 10);

`ifdef LED_SCHEDULER_BLINK_EN
        step(1'b1, 1'b1, 4'b1111, 4, 1'b1);
        idle_cycles(1'b1, 20);
`endif

        // Randomized traffic with occasional enable flips, long entries and resets.
        en_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            dur_r = ($urandom_range(0, 63) == 0) ? 255 : int'($urandom_range(0, 3));
            step(en_r, ($urandom_range(0, 2) == 0), 4'($urandom), dur_r, 1'($urandom));
            if ($urandom_range(0, 999) == 0) async_reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, meaning width of LED pattern.
REQ-002 SHALL have parameter TICK_DIVIDER, default 125000, meaning ext_clk cycles per display tick (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning pattern buffer entries (power of two, >=2).
REQ-004 SHALL have port ext_clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  permits starting/continuing playback.
REQ-007 SHALL have port input_valid  in  1  pattern request valid.
REQ-008 SHALL have port input_ready  out  1  buffer can accept.
REQ-009 SHALL have port input_pattern  in  NUM_LEDS  LED pattern to show.
REQ-010 SHALL have port input_duration  in  8  display time in ticks.
REQ-011 SHALL have port led_out  out  NUM_LEDS  registered LED drive.
REQ-012 SHALL have port busy  out  1  high while state SHOW.
REQ-013 SHALL have port done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-014 SHALL accept an entry on the ext_clk edge where input_valid and input_ready are both high; input_ready SHALL equal not-full, with no write-through when full even if a pop occurs that cycle.
REQ-015 SHALL implement FSM states IDLE and SHOW.
REQ-016 IDLE: led_out=0; when enable=1 and buffer non-empty, SHALL pop the head, load led_out and remaining=max(duration,1), clear prescaler, go SHOW.
REQ-017 Latency: entry written at edge N into an empty buffer while IDLE with enable=1 SHALL appear on led_out after edge N+1.
REQ-018 SHALL run the prescaler 0..TICK_DIVIDER-1 only in SHOW; tick pulses at terminal count, then the prescaler wraps to 0.
REQ-019 SHOW: on tick SHALL decrement remaining; on the tick where remaining==1, the entry expires.
REQ-020 On expiry with enable=1 and buffer non-empty, SHALL pop and display the next entry on the following edge with no gap cycle and stay in SHOW.
REQ-021 On expiry otherwise SHALL go IDLE, set led_out=0, pulse done for one cycle.
REQ-022 Deasserting enable mid-SHOW SHALL NOT truncate the current entry; the block SHALL stop at its expiry.
REQ-023 Duration 0 SHALL be treated as 1 tick; duration 255 SHALL last 255 ticks.

Reset
REQ-024 Reset SHALL asynchronously force: state IDLE, buffer empty, prescaler 0, led_out 0, busy 0, done 0, input_ready 1.
REQ-025 Reset mid-SHOW SHALL discard the current entry and all buffered entries.

Configuration
REQ-026 With LED_SCHEDULER_BLINK_EN defined, SHALL add port input_blink (in, 1) stored per entry; when set, led_out SHALL alternate pattern/0 each tick during SHOW, starting with pattern.
REQ-027 Without LED_SCHEDULER_BLINK_EN, input_blink SHALL NOT exist and patterns SHALL be shown steadily.

Structure
REQ-028 Shared header led_scheduler_pkg.vh SHALL hold state encodings, the duration width (8) and the default parameter values.
REQ-029 Buffering SHALL be the sub-module led_scheduler_fifo (synchronous FIFO, ext_clk, async reset); the FSM, prescaler and output register SHALL reside in led_scheduler.

Verification (TICK_DIVIDER=4, NUM_LEDS=4, FIFO_DEPTH=4)
REQ-030 Push pattern 4'b1010, duration 3, enable=1 -> led_out=1010 one edge after the accept, held 12 cycles, then 0, done pulsed once, busy low.
REQ-031 enable=0, push 5 entries back-to-back -> 4 accepted, input_ready=0 on the 5th, led_out stays 0 until enable=1.
REQ-032 Two entries (0001,d=2) and (0010,d=1), enable=1 -> 0001 for 8 cycles, 0010 for 4 cycles, no 0 cycle between them, a single done pulse.
REQ-033 Deassert enable 2 cycles into an entry with d=2 and a second entry buffered -> the first entry shows the full 8 cycles, then IDLE, and the second entry stays buffered.
REQ-034 Assert reset mid-SHOW with 3 entries buffered -> led_out=0 immediately, input_ready=1; after release with enable=1, led_out stays 0.
REQ-035 With LED_SCHEDULER_BLINK_EN, 1111, d=4, blink=1 -> led_out sequence 1111,0,1111,0, 4 cycles each.
